// File: rtl/computer_pkg.sv
// computer_pkg: shared types and constants for the computer's output-port UART stage.
package computer_pkg;
    localparam int UART_DATA_BITS  = 8;
    localparam int UART_FRAME_BITS = 10;
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} tx_state_t;
endpackage

// File: rtl/oport_fifo.sv
// oport_fifo: synchronous FIFO with extra-MSB pointers for full/empty detection.
module oport_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW:0]      r_wp, r_rp;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp <= '0;
            r_rp <= '0;
        end else begin
            if (push && !full) r_wp <= r_wp + (AW+1)'(1);
            if (pop && !empty) r_rp <= r_rp + (AW+1)'(1);
        end
    end
    always_ff @(posedge clk) begin
        if (push && !full) r_mem[r_wp[AW-1:0]] <= din;
    end
    assign full  = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    assign empty = r_wp == r_rp;
    assign dout  = r_mem[r_rp[AW-1:0]];
endmodule

// File: rtl/oport_uart_tx.sv
// oport_uart_tx: buffers oport writes in a FIFO and sends them as 8N1 UART frames.
module oport_uart_tx
    import computer_pkg::*;
#(
    parameter int CLKS_PER_BIT = 16,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [7:0] wr_data,
    input  logic       ovf_clr,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       overflow
);
    localparam int BW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(UART_DATA_BITS);
    tx_state_t   r_state, w_state_d;
    logic [BW-1:0] r_baud;
    logic [IW-1:0] r_bit;
    logic [7:0]  r_shift, w_shift_d, w_dout;
    logic        r_tx, r_ovf, w_tx_d, w_pop, w_full, w_empty, w_done;

    oport_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (wr_en),
        .pop   (w_pop),
        .din   (wr_data),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty)
    );

    assign w_done = r_baud == BW'(CLKS_PER_BIT - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_ovf   <= 1'b0;
        end else begin
            r_state <= w_state_d;
            r_baud  <= (r_state == IDLE || w_done) ? '0 : r_baud + BW'(1);
            r_bit   <= (r_state != DATA) ? '0 : w_done ? r_bit + IW'(1) : r_bit;
            r_shift <= w_shift_d;
            r_tx    <= w_tx_d;
            // a dropped write beats a same-edge clear
            r_ovf   <= (wr_en && w_full) || (r_ovf && !ovf_clr);
        end
    end

    always_comb begin
        w_state_d = r_state;
        w_pop     = 1'b0;
        case (r_state)
            IDLE: if (!w_empty) begin
                w_state_d = START;
                w_pop     = 1'b1;
            end
            START: if (w_done) w_state_d = DATA;
            DATA: if (w_done && r_bit == IW'(UART_DATA_BITS - 1)) w_state_d = STOP;
            STOP: if (w_done) begin
                w_state_d = w_empty ? IDLE : START;
                w_pop     = !w_empty;
            end
            default: w_state_d = IDLE;
        endcase
    end

    // tx is registered from the next state so the line moves on the same edge as the FSM
    always_comb begin
        w_shift_d = w_pop ? w_dout : (r_state == DATA && w_done) ? r_shift >> 1 : r_shift;
        w_tx_d    = (w_state_d == START) ? 1'b0 : (w_state_d == DATA) ? w_shift_d[0] : 1'b1;
    end

    assign tx       = r_tx;
    assign busy     = !w_empty || r_state != IDLE;
    assign full     = w_full;
    assign overflow = r_ovf;
endmodule

// File: tb/tb_oport_uart_tx.sv
// tb_oport_uart_tx: directed stimulus with a UART-decoding monitor checked against an expected-byte queue.
module tb_oport_uart_tx;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       wr_en = 1'b0;
    logic [7:0] wr_data = '0;
    logic       ovf_clr = 1'b0;
    logic       tx, busy, full, overflow;
    int         checks = 0;
    int         errors = 0;
    logic [7:0] sb [$];

    oport_uart_tx #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .ovf_clr  (ovf_clr),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", {31'd0, busy}, 32'd0);
        repeat (5) @(negedge clk);
    endtask

    // Monitor: decode frames on tx, sampling mid-bit, and compare with the expected queue
    logic [7:0] rx_b;
    bit         rx_abort;
    initial begin
        forever begin
            @(negedge clk);
            if (reset && !tx) begin
                rx_abort = 1'b0;
                repeat (2) @(negedge clk);
                if (!reset) rx_abort = 1'b1;
                else chk("start_bit", {31'd0, tx}, 32'd0);
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(negedge clk);
                    if (!reset) rx_abort = 1'b1;
                    rx_b[i] = tx;
                end
                repeat (4) @(negedge clk);
                if (!reset) rx_abort = 1'b1;
                if (!rx_abort) begin
                    chk("stop_bit", {31'd0, tx}, 32'd1);
                    if (sb.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_frame actual=%0h required=none", rx_b);
                    end else begin
                        chk("rx_byte", {24'd0, rx_b}, {24'd0, sb.pop_front()});
                    end
                end
            end
        end
    end

    initial begin
        logic [5:0] win;
        int nb, last_busy, bad;
        logic tx40, tx41, tx81;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_tx", {31'd0, tx}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_ovf", {31'd0, overflow}, 32'd0);
        reset = 1'b1;
        // idle line stays quiet
        bad = 0;
        for (int c = 0; c < 1000; c++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        chk("idle_quiet", bad, 0);
        // single frame 0xA5: timing and busy length
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'hA5; sb.push_back(8'hA5);
        @(negedge clk);
        wr_en = 1'b0;
        win = '0; nb = 0;
        for (int c = 0; c < 60; c++) begin
            if (c < 6) win[5-c] = tx;
            if (busy) nb++;
            @(negedge clk);
        end
        chk("a5_tx_window", {26'd0, win}, {26'd0, 6'b100001});
        chk("a5_busy_cycles", nb, 41);
        wait_idle();
        // back-to-back frames
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h01; sb.push_back(8'h01);
        @(negedge clk);
        wr_data = 8'hFF; sb.push_back(8'hFF);
        @(negedge clk);
        wr_data = 8'h00; sb.push_back(8'h00);
        @(negedge clk);
        wr_en = 1'b0;
        last_busy = -1; tx40 = 1'b0; tx41 = 1'b1; tx81 = 1'b1;
        for (int c = 2; c < 200; c++) begin
            if (busy) last_busy = c;
            if (c == 40) tx40 = tx;
            if (c == 41) tx41 = tx;
            if (c == 81) tx81 = tx;
            @(negedge clk);
        end
        chk("b2b_last_busy", last_busy, 120);
        chk("b2b_stop1", {31'd0, tx40}, 32'd1);
        chk("b2b_start2", {31'd0, tx41}, 32'd0);
        chk("b2b_start3", {31'd0, tx81}, 32'd0);
        wait_idle();
        // overflow on the sixth consecutive write
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(8'h10 + i);
            if (i < 5) sb.push_back(8'(8'h10 + i));
        end
        @(negedge clk);
        wr_en = 1'b0;
        chk("ovf_full", {31'd0, full}, 32'd1);
        chk("ovf_set", {31'd0, overflow}, 32'd1);
        wait_idle();
        // clear overflow
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        chk("ovf_clr", {31'd0, overflow}, 32'd0);
        // drop and clear on the same edge: set wins
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_en = 1'b1; wr_data = 8'(8'h20 + i); sb.push_back(8'(8'h20 + i));
        end
        @(negedge clk);
        chk("pre_drop_ovf", {31'd0, overflow}, 32'd0);
        chk("pre_drop_full", {31'd0, full}, 32'd1);
        wr_data = 8'h25; ovf_clr = 1'b1;
        @(negedge clk);
        wr_en = 1'b0; ovf_clr = 1'b0;
        chk("ovf_set_wins", {31'd0, overflow}, 32'd1);
        ovf_clr = 1'b1;
        @(negedge clk);
        ovf_clr = 1'b0;
        wait_idle();
        // reset during bit 3 of 0x3C
        @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        repeat (18) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("midrst_tx", {31'd0, tx}, 32'd1);
        chk("midrst_busy", {31'd0, busy}, 32'd0);
        chk("midrst_full", {31'd0, full}, 32'd0);
        repeat (10) @(negedge clk);
        chk("midrst_tx_held", {31'd0, tx}, 32'd1);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        wr_en = 1'b1; wr_data = 8'h55; sb.push_back(8'h55);
        @(negedge clk);
        wr_en = 1'b0;
        repeat (3) @(negedge clk);
        wait_idle();
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
